// File: rtl/ps2_scancode_rx_pkg.sv
// Shared definitions for the PS/2 scancode receiver.
//   - Set-2 scancode constants (extended prefix, break prefix, error codes)
//   - Frame receiver FSM state type
//   - Timeout length derivation from clock frequency and microseconds
package ps2_scancode_rx_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ERR0  = 8'h00;
  localparam logic [7:0] SC_ERR1  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  function automatic int unsigned timeout_cycles(input int unsigned clk_hz,
                                                 input int unsigned timeout_us);
    return (clk_hz / 1000000) * timeout_us;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Conditions the raw PS/2 clock line.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset
//   raw    in  raw line, asynchronous to clk
//   fall   out one-cycle strobe on a falling edge of the filtered level
// The filtered level only follows the synchronized line after FILTER_LEN
// consecutive samples that all disagree with the current filtered level.
module ps2_line_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic fall
);

  localparam int unsigned CW = $clog2(FILTER_LEN + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Lines idle high, so reset to 1 to avoid a spurious edge after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      fall  <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(FILTER_LEN - 1)) begin
        level <= sync2;
        cnt   <= '0;
        fall  <= level & ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver with Set-2 make/break/extended decoding.
//   clk           in  system clock (CLK_HZ)
//   reset         in  asynchronous active-high reset
//   ps2_clk       in  raw PS/2 clock
//   ps2_data      in  raw PS/2 data
//   key_code      out last decoded key byte, held until the next key event
//   key_extended  out last key event was E0-prefixed
//   new_key       out one-cycle pulse on a key press (repeats suppressed)
//   key_released  out one-cycle pulse on a key release
//   frame_err     out one-cycle pulse on parity/stop/timeout/error-code
//   busy          out frame reception in progress
module ps2_scancode_rx
  import ps2_scancode_rx_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TIMEOUT_US = 1000,
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       new_key,
  output logic       key_released,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned TO_CYC = timeout_cycles(CLK_HZ, TIMEOUT_US);
  localparam int unsigned TW     = $clog2(TO_CYC + 1);

  logic          strobe;
  logic          data_s1;
  logic          data_s;
  rx_state_t     state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_ok;
  logic [TW-1:0] tcnt;
  logic          ext;
  logic          brk;
  logic          held_valid;
  logic [8:0]    held_code;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk   (clk),
    .reset (reset),
    .raw   (ps2_clk),
    .fall  (strobe)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_s1 <= 1'b1;
      data_s  <= 1'b1;
    end else begin
      data_s1 <= ps2_data;
      data_s  <= data_s1;
    end
  end

  assign busy = (state != ST_IDLE);

  // The byte is decoded on the accepting stop-bit strobe so the event
  // outputs register one clock after that strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      par_ok       <= 1'b0;
      tcnt         <= '0;
      ext          <= 1'b0;
      brk          <= 1'b0;
      held_valid   <= 1'b0;
      held_code    <= '0;
      key_code     <= '0;
      key_extended <= 1'b0;
      new_key      <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      new_key      <= 1'b0;
      key_released <= 1'b0;
      frame_err    <= 1'b0;

      if (strobe) begin
        tcnt <= '0;
      end else if (state != ST_IDLE && tcnt != TW'(TO_CYC)) begin
        tcnt <= tcnt + TW'(1);
      end

      case (state)
        ST_IDLE: begin
          if (strobe && !data_s) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (strobe) begin
            shreg   <= {data_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_PARITY;
          end
        end
        ST_PARITY: begin
          if (strobe) begin
            par_ok <= (^shreg) ^ data_s;
            state  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (strobe) begin
            state <= ST_IDLE;
            if (!(data_s && par_ok)) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else if (shreg == SC_EXT) begin
              ext <= 1'b1;
            end else if (shreg == SC_BREAK) begin
              brk <= 1'b1;
            end else if (shreg == SC_ERR0 || shreg == SC_ERR1) begin
              frame_err <= 1'b1;
              ext       <= 1'b0;
              brk       <= 1'b0;
            end else begin
              ext <= 1'b0;
              brk <= 1'b0;
              if (brk) begin
                key_code     <= shreg;
                key_extended <= ext;
                key_released <= 1'b1;
                if (held_valid && held_code == {ext, shreg}) held_valid <= 1'b0;
              end else if (!(held_valid && held_code == {ext, shreg})) begin
                key_code     <= shreg;
                key_extended <= ext;
                new_key      <= 1'b1;
                held_code    <= {ext, shreg};
                held_valid   <= 1'b1;
              end
            end
          end
        end
      endcase

      if (state != ST_IDLE && !strobe && tcnt == TW'(TO_CYC)) begin
        state     <= ST_IDLE;
        frame_err <= 1'b1;
        ext       <= 1'b0;
        brk       <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_scancode_rx.sv
module tb_ps2_scancode_rx;

  localparam int HALF = 16;   // PS/2 half bit period in clk cycles
  localparam int GAP  = 30;   // idle cycles after each frame
  localparam int K_NONE = 0, K_NEW = 1, K_REL = 2, K_ERR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       key_extended, new_key, key_released, frame_err, busy;

  ps2_scancode_rx #(.CLK_HZ(50000000), .TIMEOUT_US(1000), .FILTER_LEN(8)) dut (
    .clk          (clk),
    .reset        (rst),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_code     (key_code),
    .key_extended (key_extended),
    .new_key      (new_key),
    .key_released (key_released),
    .frame_err    (frame_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         kind;
    logic [7:0] code;
    logic       ext;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [7:0] b;
    logic       pf;
    logic       stop;
    int         kind;
    logic [7:0] code;
    logic       ext;
  } vec_t;

  ev_t  evq[$];
  vec_t tbl[$];
  int   cyc = 0;
  int   fall_cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   overlap = 0, wide = 0, kc_bad = 0;
  logic p_nk = 0, p_kr = 0, p_fe = 0;
  logic [7:0] p_kc = 0;
  logic       p_ke = 0;

  // Reference model state
  logic       m_ext, m_brk, m_hv, m_ke;
  logic [8:0] m_hc;
  logic [7:0] m_kc;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (int'(new_key) + int'(key_released) + int'(frame_err) > 1) overlap++;
      if ((new_key && p_nk) || (key_released && p_kr) || (frame_err && p_fe)) wide++;
      if ((key_code != p_kc || key_extended != p_ke) && !new_key && !key_released) kc_bad++;
      if (new_key)      evq.push_back('{K_NEW, key_code, key_extended, cyc});
      if (key_released) evq.push_back('{K_REL, key_code, key_extended, cyc});
      if (frame_err)    evq.push_back('{K_ERR, key_code, key_extended, cyc});
    end
    p_nk = new_key; p_kr = key_released; p_fe = frame_err;
    p_kc = key_code; p_ke = key_extended;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_range(input string name, input int got, input int lo, input int hi);
    n_checks++;
    if (got < lo || got > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_hv = 0; m_hc = '0; m_kc = '0; m_ke = 0;
  endtask

  // Applies the decode rules to one received frame.
  task automatic model(input logic [7:0] b, input logic ok, output int kind);
    logic [8:0] key;
    kind = K_NONE;
    key = {m_ext, b};
    if (!ok || b == 8'h00 || b == 8'hFF) begin
      kind = K_ERR; m_ext = 0; m_brk = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else begin
      if (m_brk) begin
        kind = K_REL; m_kc = b; m_ke = m_ext;
        if (m_hv && m_hc == key) m_hv = 0;
      end else if (!(m_hv && m_hc == key)) begin
        kind = K_NEW; m_kc = b; m_ke = m_ext; m_hv = 1; m_hc = key;
      end
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b0;
    fall_cyc = cyc;
    repeat (HALF) @(posedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic pf, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ pf);
    ps2_bit(stop);
    ps2_data = 1'b1;
    repeat (GAP) @(posedge clk);
  endtask

  task automatic run_frame(input logic [7:0] b, input logic pf, input logic stop,
                           input int kind, input logic [7:0] code, input logic ext,
                           input string tag);
    evq.delete();
    send_frame(b, pf, stop);
    @(negedge clk);
    check({tag, " events"}, evq.size(), (kind == K_NONE) ? 0 : 1);
    if (kind != K_NONE && evq.size() == 1) begin
      check({tag, " kind"}, evq[0].kind, kind);
      check_range({tag, " latency"}, evq[0].cyc - fall_cyc, 6, 20);
      if (kind != K_ERR) begin
        check({tag, " code"}, evq[0].code, code);
        check({tag, " ext"}, evq[0].ext, ext);
      end
    end
    check({tag, " key_code"}, key_code, m_kc);
    check({tag, " key_ext"}, key_extended, m_ke);
    check({tag, " busy"}, busy, 0);
  endtask

  task automatic add(input logic [7:0] b, input logic pf, input logic stop,
                     input int kind, input logic [7:0] code, input logic ext);
    vec_t v;
    v.b = b; v.pf = pf; v.stop = stop; v.kind = kind; v.code = code; v.ext = ext;
    tbl.push_back(v);
  endtask

  initial begin
    int         k;
    int         t0;
    logic [7:0] b;
    logic       pf, stop;

    model_reset();
    add(8'h1A, 0, 1, K_NEW,  8'h1A, 0);
    add(8'hF0, 0, 1, K_NONE, 8'h00, 0);
    add(8'h1A, 0, 1, K_REL,  8'h1A, 0);
    add(8'h1A, 0, 1, K_NEW,  8'h1A, 0);
    add(8'h1A, 0, 1, K_NONE, 8'h00, 0);
    add(8'h1A, 0, 1, K_NONE, 8'h00, 0);
    add(8'h1A, 1, 1, K_ERR,  8'h00, 0);
    add(8'h22, 0, 1, K_NEW,  8'h22, 0);
    add(8'hE0, 0, 1, K_NONE, 8'h00, 0);
    add(8'h75, 0, 1, K_NEW,  8'h75, 1);
    add(8'h75, 0, 1, K_NEW,  8'h75, 0);
    add(8'hE0, 0, 1, K_NONE, 8'h00, 0);
    add(8'hF0, 0, 1, K_NONE, 8'h00, 0);
    add(8'h75, 0, 1, K_REL,  8'h75, 1);
    add(8'h00, 0, 1, K_ERR,  8'h00, 0);
    add(8'hF0, 0, 1, K_NONE, 8'h00, 0);
    add(8'hFF, 0, 1, K_ERR,  8'h00, 0);
    add(8'h75, 0, 1, K_NONE, 8'h00, 0);
    add(8'h1C, 0, 0, K_ERR,  8'h00, 0);
    add(8'h1C, 0, 1, K_NEW,  8'h1C, 0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("reset outputs", {key_code, key_extended, new_key, key_released, frame_err, busy}, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);

    foreach (tbl[i]) begin
      model(tbl[i].b, !tbl[i].pf && tbl[i].stop, k);
      run_frame(tbl[i].b, tbl[i].pf, tbl[i].stop, tbl[i].kind, tbl[i].code, tbl[i].ext,
                $sformatf("vec%0d", i));
    end

    // Partial frame after a break prefix: timeout must abort and drop the prefix.
    model(8'hF0, 1'b1, k);
    run_frame(8'hF0, 0, 1, K_NONE, 8'h00, 0, "to_prefix");
    evq.delete();
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    t0 = fall_cyc;
    repeat (20) @(posedge clk);
    @(negedge clk);
    check("to busy", busy, 1);
    for (int i = 0; i < 60000 && evq.size() == 0; i++) @(posedge clk);
    @(negedge clk);
    check("to events", evq.size(), 1);
    if (evq.size() == 1) begin
      check("to kind", evq[0].kind, K_ERR);
      check_range("to delay", evq[0].cyc - t0, 49990, 50040);
    end
    check("to busy drop", busy, 0);
    model(8'h00, 1'b0, k);
    model(8'h1B, 1'b1, k);
    run_frame(8'h1B, 0, 1, K_NEW, 8'h1B, 0, "to_after");

    // Reset in the middle of a break-prefix frame.
    model(8'hF0, 1'b1, k);
    run_frame(8'hF0, 0, 1, K_NONE, 8'h00, 0, "rst_prefix");
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    ps2_data = 1'b0;
    ps2_clk = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst busy before", busy, 1);
    rst = 1'b1;
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst mid outputs", {key_code, key_extended, new_key, key_released, frame_err, busy}, 0);
    rst = 1'b0;
    model_reset();
    repeat (GAP) @(posedge clk);
    model(8'h1A, 1'b1, k);
    run_frame(8'h1A, 0, 1, K_NEW, 8'h1A, 0, "rst_after");

    // Randomized traffic against the reference model.
    for (int n = 0; n < 36; n++) begin
      case ($urandom_range(0, 9))
        0: b = 8'hE0;
        1: b = 8'hF0;
        2: b = 8'h1A;
        3: b = 8'h1B;
        4: b = 8'h22;
        5: b = 8'h75;
        6: b = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
        default: b = 8'($urandom_range(1, 254));
      endcase
      pf   = ($urandom_range(0, 9) == 0);
      stop = ($urandom_range(0, 19) != 0);
      model(b, !pf && stop, k);
      run_frame(b, pf, stop, k, m_kc, m_ke, $sformatf("rnd%0d_%02h", n, b));
    end

    check("pulse overlap", overlap, 0);
    check("pulse width", wide, 0);
    check("key_code stability", kc_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_rx.md
Name: ps2_scancode_rx

Overview:
Upstream stage of the piano front-end. It receives raw PS/2 keyboard frames and decodes Set-2 make/break/extended prefixes. It emits single-cycle key events (new_key, key_released) with a stable key_code. The kb2piano note mapper and the key-status register consume these events. It replaces ad-hoc PS/2 sampling with a filtered, time-out-protected receiver.

Parameters:
CLK_HZ, 50000000, frequency of clk in Hz
TIMEOUT_US, 1000, max gap between PS/2 falling edges inside a frame before abort
FILTER_LEN, 8, consecutive equal samples required before filtered ps2_clk changes

Ports:
clk  in  1  system clock (CLK_HZ)
reset  in  1  asynchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock, asynchronous to clk
ps2_data  in  1  raw PS/2 data, asynchronous to clk
key_code  out  8  last decoded make/break code, held until next event
key_extended  out  1  1 if the last event was preceded by E0
new_key  out  1  one-cycle pulse: a new key press (typematic repeats suppressed)
key_released  out  1  one-cycle pulse: a key release (F0 prefix seen)
frame_err  out  1  one-cycle pulse: parity, stop, timeout or invalid-byte error
busy  out  1  high while a frame is being received (state != IDLE)

Behaviour:
- Reset is asynchronous and active-high, on one clock domain (clk). On reset, all outputs are 0, the FSM goes to IDLE, and prefix flags, held_valid and held_code are cleared. Reset mid-frame discards the partial frame.
- Input conditioning:
  - ps2_clk and ps2_data each pass a 2-flop synchronizer.
  - The filtered clock changes only after FILTER_LEN consecutive identical synchronized samples.
  - A falling edge of the filtered clock produces a one-cycle sample strobe, which samples synchronized ps2_data.
- FSM: IDLE -> DATA -> PARITY -> STOP -> IDLE.
  - IDLE: on strobe with data 0 (start bit), go to DATA with bit_cnt=0. Data 1 is ignored; stay in IDLE with no error.
  - DATA: shift data in LSB-first. After the 8th bit (bit_cnt==7), go to PARITY.
  - PARITY: capture the bit. Odd parity requires XOR(data[7:0], parity)=1.
  - STOP: requires stop bit=1 and valid parity. If so, the byte is accepted and the FSM returns to IDLE. Otherwise frame_err pulses, prefix flags clear, and the FSM returns to IDLE.
- Timeout:
  - TIMEOUT_CYCLES = CLK_HZ/1000000*TIMEOUT_US.
  - A counter resets on every strobe and counts in non-IDLE states.
  - When the counter reaches TIMEOUT_CYCLES: frame_err pulses, prefix flags clear, FSM goes to IDLE.
  - The counter saturates and never wraps.
- Byte decode, performed in the cycle after the accepting STOP strobe (latency 1 clk from stop-bit strobe to output pulse):
  - 0xE0: set ext flag; no pulse.
  - 0xF0: set brk flag; no pulse.
  - 0x00 or 0xFF (keyboard error codes): frame_err pulse; clear flags.
  - Any other byte with brk=1:
    - key_code<=byte, key_extended<=ext, key_released pulses, flags clear.
    - If held_valid and held_code=={ext,byte}, held_valid clears.
  - Any other byte with brk=0:
    - If held_valid and held_code=={ext,byte}, it is a typematic repeat: no pulse, flags clear.
    - Otherwise key_code<=byte, key_extended<=ext, new_key pulses, held_code<={ext,byte}, held_valid<=1, flags clear.
- new_key, key_released and frame_err are mutually exclusive and never high for more than 1 cycle.
- busy=1 in DATA/PARITY/STOP.
- key_code and key_extended change only on a new_key or key_released cycle.

Decomposition:
- Shared package: scancode constants (SC_EXT=8'hE0, SC_BREAK=8'hF0, SC_ERR0=8'h00, SC_ERR1=8'hFF), the FSM state encoding, and the TIMEOUT_CYCLES derivation function.
- One sub-module, ps2_line_filter: synchronizer, FILTER_LEN glitch filter and falling-edge strobe. It is instantiated once, for the clock line; the data line is only synchronized.

Test Plan:
- Frame 0x1A (Z), odd parity bit 0, stop 1 -> new_key=1 for exactly 1 clk, one clk after the stop strobe; key_code=0x1A, key_extended=0, frame_err=0.
- 0x1A, then 0xF0, 0x1A -> one new_key, then one key_released with key_code=0x1A; second 0x1A after release -> new_key again.
- Typematic 0x1A x3 with no break -> exactly one new_key pulse; key_code stays 0x1A.
- 0x1A sent with parity bit 1 -> frame_err pulse, no new_key, key_code unchanged; next valid 0x22 -> new_key with key_code=0x22.
- Start bit plus 5 data bits, then line idle (CLK_HZ=50e6, TIMEOUT_US=1000) -> frame_err at 50000 clks after last edge, busy drops; following valid 0x1B decodes normally.
- 0xE0, 0x75 -> new_key, key_code=0x75, key_extended=1. Reset asserted mid-frame of 0xF0 -> outputs 0; subsequent 0x1A yields new_key (not key_released).
